md_issue_ctrl: RTL

- E-stage issue/stall controller that drives the multiply/divide unit's command side: start, MDop, operands, HIwrite and LOwrite.
- Consumes the unit's Busy, stalls MD-class instructions (mult/div/msub/mthi/mtlo/mfhi/mflo) in E while an operation is in flight, and suppresses issue of flushed instructions.
- Tracks the start→Busy gap, runs a watchdog, counts issued ops and keeps a sticky error flag.

---
 rtl/md_issue_ctrl_pkg.sv | 22 ++
 rtl/md_issue_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/md_issue_ctrl_pkg.sv
// rtl/md_issue_ctrl_pkg.sv - shared MDop codes and issue-controller state encoding
package md_issue_ctrl_pkg;

  // MDop codes understood by the multiply/divide unit
  localparam logic [2:0] MULTU = 3'b000;
  localparam logic [2:0] MULT  = 3'b001;
  localparam logic [2:0] DIVU  = 3'b010;
  localparam logic [2:0] DIV   = 3'b011;
  localparam logic [2:0] MSUB  = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } md_state_t;

  // Codes above MSUB are not defined for the unit
  function automatic logic is_bad_mdop(input logic [2:0] op);
    return op > MSUB;
  endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - E-stage issue/stall controller for the multiply/divide unit
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_valid,
  input  logic             e_flush,
  input  logic             e_start,
  input  logic [2:0]       e_mdop,
  input  logic             e_mthi,
  input  logic             e_mtlo,
  input  logic             e_mfhilo,
  input  logic [31:0]      e_rs,
  input  logic [31:0]      e_rt,
  input  logic             md_busy,
  output logic             md_start,
  output logic [2:0]       md_op,
  output logic [31:0]      md_a,
  output logic [31:0]      md_b,
  output logic             md_hiwrite,
  output logic             md_lowrite,
  output logic             stall_e,
  output logic             err,
  output logic [CNT_W-1:0] issue_count
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  md_state_t        r_state, w_state_nxt;
  logic [WD_W-1:0]  r_wd_cnt, w_wd_nxt;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_issue_count, w_count_nxt;

  logic w_live, w_mdcls, w_stall, w_cmd_ok, w_start, w_conflict, w_bad_op;

  // Reset is folded into w_live so every command output and the stall drop to 0 while reset is low
  assign w_live   = reset & e_valid & ~e_flush;
  assign w_mdcls  = e_start | e_mthi | e_mtlo | e_mfhilo;
  // A start seen in BUSY waits one more cycle even when Busy has already fallen
  assign w_stall  = w_live & w_mdcls &
                    ((r_state == LAUNCH) | md_busy | ((r_state == BUSY) & e_start));
  assign w_cmd_ok = w_live & ~w_stall & (r_state != LAUNCH);
  assign w_start  = w_cmd_ok & e_start;

  assign md_start   = w_start;
  assign md_op      = w_start ? e_mdop : MULTU;
  assign md_a       = reset ? e_rs : 32'd0;
  assign md_b       = reset ? e_rt : 32'd0;
  assign md_hiwrite = w_cmd_ok & e_mthi & ~e_start;
  assign md_lowrite = w_cmd_ok & e_mtlo & ~e_start & ~e_mthi;
  assign stall_e    = w_stall;

  assign w_conflict = w_live & ((e_start & e_mthi) | (e_start & e_mtlo) | (e_mthi & e_mtlo));
  assign w_bad_op   = w_start & is_bad_mdop(e_mdop);

  assign err         = r_err;
  assign issue_count = r_issue_count;

  // Next state, watchdog, sticky error and issue counter
  always_comb begin
    w_state_nxt = r_state;
    w_wd_nxt    = r_wd_cnt;
    w_err_nxt   = r_err | w_conflict | w_bad_op;
    w_count_nxt = r_issue_count;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = LAUNCH;
          w_count_nxt = r_issue_count + CNT_W'(1);
        end
      end
      LAUNCH: begin
        if (md_busy) begin
          w_state_nxt = BUSY;
          w_wd_nxt    = '0;
        end else begin
          // the unit never raised Busy: it ignored the start
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (!md_busy) begin
          w_state_nxt = IDLE;
        end else if (r_wd_cnt == WD_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_wd_nxt = r_wd_cnt + WD_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_wd_cnt      <= '0;
      r_err         <= 1'b0;
      r_issue_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_wd_cnt      <= w_wd_nxt;
      r_err         <= w_err_nxt;
      r_issue_count <= w_count_nxt;
    end
  end

endmodule
